// File: rtl/fp16_mantissa_accumulator_if.sv
// fp16_mantissa_accumulator_if: beat input and result output handshake bundle
interface fp16_mantissa_accumulator_if;
   logic        in_valid, in_ready, in_last;
   logic [10:0] mantissa_A_in, mantissa_B_in, mantissa_C_in, mantissa_D_in;
   logic        sign_A, sign_B, sign_C, sign_D;
   logic [4:0]  max_exponent;
   logic        out_valid, out_ready;
   logic [15:0] result;
   modport master (
      output in_valid, in_last, mantissa_A_in, mantissa_B_in, mantissa_C_in, mantissa_D_in,
      output sign_A, sign_B, sign_C, sign_D, max_exponent, out_ready,
      input  in_ready, out_valid, result
   );
   modport slave (
      input  in_valid, in_last, mantissa_A_in, mantissa_B_in, mantissa_C_in, mantissa_D_in,
      input  sign_A, sign_B, sign_C, sign_D, max_exponent, out_ready,
      output in_ready, out_valid, result
   );
endinterface

// File: rtl/fp16_mantissa_accumulator.sv
// fp16_mantissa_accumulator: sums four aligned lanes per beat, accumulates a group, normalises to FP16
module fp16_mantissa_accumulator #(
   parameter int ACC_W    = 16,
   parameter int EXP_BIAS = 15
) (
   input logic                        clk,
   input logic                        reset,
   fp16_mantissa_accumulator_if.slave bus
);
   localparam logic signed [7:0] EXP_MAX = 8'(2 * EXP_BIAS + 1);
   typedef enum logic [1:0] {IDLE, ACCUM, NORM, HOLD} state_t;
   state_t                  state_q, state_d;
   logic                    in_ready_q, in_ready_d, out_valid_q, out_valid_d;
   logic [15:0]             result_q, result_d, pack;
   logic                    s1_valid_q, s1_valid_d, s1_last_q, s1_last_d;
   logic signed [13:0]      s1_sum_q, s1_sum_d;
   logic [4:0]              s1_exp_q, s1_exp_d;
   logic signed [ACC_W-1:0] acc_q, acc_d, acc_new, add_a, add_b, s_ext;
   logic signed [6:0]       acc_exp_q, acc_exp_d, exp_new, exp_e;
   logic [7:0]              diff;
   logic [ACC_W:0]          sum;
   logic                    ovf, xfer;
   logic [ACC_W-1:0]        mag_new;
   logic                    norm_sign_q, norm_sign_d;
   logic [ACC_W-1:0]        norm_mag_q, norm_mag_d;
   logic signed [7:0]       norm_exp_q, norm_exp_d;
   function automatic logic signed [13:0] lane(input logic s, input logic [10:0] m);
      logic signed [13:0] v;
      v = signed'({3'b000, m});
      return s ? -v : v;
   endfunction
   // Arithmetic shift that flushes to zero once every significant bit is gone
   function automatic logic signed [ACC_W-1:0] sra(input logic signed [ACC_W-1:0] v, input logic [7:0] n);
      if (n >= 8'(ACC_W - 1)) return '0;
      return v >>> n;
   endfunction
   assign xfer          = bus.in_valid && in_ready_q;
   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.result    = result_q;
   // Stage 1: signed sum of the four lanes of an accepted beat
   always_comb begin
      s1_valid_d = xfer;
      s1_last_d  = xfer ? bus.in_last : s1_last_q;
      s1_exp_d   = xfer ? bus.max_exponent : s1_exp_q;
      s1_sum_d   = xfer ? lane(bus.sign_A, bus.mantissa_A_in) + lane(bus.sign_B, bus.mantissa_B_in)
                        + lane(bus.sign_C, bus.mantissa_C_in) + lane(bus.sign_D, bus.mantissa_D_in) : s1_sum_q;
   end
   // Stage 2: align accumulator and beat to the larger exponent, add, renormalise one bit on overflow
   always_comb begin
      exp_e   = signed'({2'b00, s1_exp_q});
      s_ext   = ACC_W'(s1_sum_q);
      diff    = {exp_e[6], exp_e} - {acc_exp_q[6], acc_exp_q};
      add_a   = (state_q == IDLE) ? '0 : diff[7] ? acc_q : sra(acc_q, diff);
      add_b   = (state_q != IDLE && diff[7]) ? sra(s_ext, -diff) : s_ext;
      sum     = {add_a[ACC_W-1], add_a} + {add_b[ACC_W-1], add_b};
      ovf     = sum[ACC_W] != sum[ACC_W-1];
      acc_new = ovf ? sum[ACC_W:1] : sum[ACC_W-1:0];
      exp_new = ((state_q != IDLE && diff[7]) ? acc_exp_q : exp_e) + (ovf ? 7'sd1 : 7'sd0);
      mag_new = acc_new[ACC_W-1] ? ACC_W'(-acc_new) : acc_new;
   end
   // Group FSM: accumulate, shift magnitude until the hidden bit sits at bit 10, then hold the result
   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      acc_exp_d   = acc_exp_q;
      norm_sign_d = norm_sign_q;
      norm_mag_d  = norm_mag_q;
      norm_exp_d  = norm_exp_q;
      result_d    = result_q;
      out_valid_d = out_valid_q;
      in_ready_d  = (xfer && bus.in_last) ? 1'b0 : in_ready_q;
      pack        = (norm_exp_q >= EXP_MAX) ? {norm_sign_q, 5'h1F, 10'h000}
                  : (norm_exp_q <= 8'sd0) ? 16'h0000 : {norm_sign_q, norm_exp_q[4:0], norm_mag_q[9:0]};
      case (state_q)
         IDLE, ACCUM: if (s1_valid_q) begin
            acc_d       = acc_new;
            acc_exp_d   = exp_new;
            norm_sign_d = acc_new[ACC_W-1];
            norm_mag_d  = mag_new;
            norm_exp_d  = 8'(exp_new);
            state_d     = s1_last_q ? NORM : ACCUM;
         end
         NORM: if (norm_mag_q == '0) begin
            result_d    = 16'h0000;
            out_valid_d = 1'b1;
            state_d     = HOLD;
         end else if (|norm_mag_q[ACC_W-1:11]) begin
            norm_mag_d = norm_mag_q >> 1;
            norm_exp_d = norm_exp_q + 8'sd1;
         end else if (!norm_mag_q[10]) begin
            norm_mag_d = norm_mag_q << 1;
            norm_exp_d = norm_exp_q - 8'sd1;
         end else begin
            result_d    = pack;
            out_valid_d = 1'b1;
            state_d     = HOLD;
         end
         default: if (bus.out_ready) begin
            out_valid_d = 1'b0;
            in_ready_d  = 1'b1;
            acc_d       = '0;
            acc_exp_d   = '0;
            state_d     = IDLE;
         end
      endcase
   end
   // State registers; reset discards any partial group
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         result_q    <= 16'h0000;
         s1_valid_q  <= 1'b0;
         s1_last_q   <= 1'b0;
         s1_sum_q    <= '0;
         s1_exp_q    <= '0;
         acc_q       <= '0;
         acc_exp_q   <= '0;
         norm_sign_q <= 1'b0;
         norm_mag_q  <= '0;
         norm_exp_q  <= '0;
      end else begin
         state_q     <= state_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         result_q    <= result_d;
         s1_valid_q  <= s1_valid_d;
         s1_last_q   <= s1_last_d;
         s1_sum_q    <= s1_sum_d;
         s1_exp_q    <= s1_exp_d;
         acc_q       <= acc_d;
         acc_exp_q   <= acc_exp_d;
         norm_sign_q <= norm_sign_d;
         norm_mag_q  <= norm_mag_d;
         norm_exp_q  <= norm_exp_d;
      end
   end
endmodule

// File: tb/tb_fp16_mantissa_accumulator.sv
// tb_fp16_mantissa_accumulator: directed vectors for group sum, normalisation, backpressure and reset
module tb_fp16_mantissa_accumulator;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   fp16_mantissa_accumulator_if bus();
   fp16_mantissa_accumulator #(.ACC_W(16), .EXP_BIAS(15)) dut (.clk(clk), .reset(reset), .bus(bus));
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   typedef struct {
      logic [3:0][10:0] m;
      logic [3:0]       s;
      logic [4:0]       e;
      logic             last;
      logic [15:0]      res;
      int               lat;
   } vec_t;
   vec_t tv[$];
   localparam logic [43:0] ALL400 = {4{11'h400}};
   localparam logic [43:0] ALL7FF = {4{11'h7FF}};
   localparam logic [43:0] A400   = 44'h400;
   localparam logic [43:0] A200   = 44'h200;
   localparam logic [43:0] A4B7FF = {11'h0, 11'h0, 11'h7FF, 11'h400};
   function automatic vec_t mk(logic [43:0] m, logic [3:0] s, logic [4:0] e, logic last, logic [15:0] res, int lat);
      return '{m: m, s: s, e: e, last: last, res: res, lat: lat};
   endfunction
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic send(input vec_t b, output int k);
      int n = 0;
      while (!bus.in_ready && n < 50) begin
         tick();
         n++;
      end
      if (!bus.in_ready) chk("in_ready_timeout", 32'(bus.in_ready), 1);
      bus.mantissa_A_in = b.m[0];
      bus.mantissa_B_in = b.m[1];
      bus.mantissa_C_in = b.m[2];
      bus.mantissa_D_in = b.m[3];
      {bus.sign_D, bus.sign_C, bus.sign_B, bus.sign_A} = b.s;
      bus.max_exponent = b.e;
      bus.in_last = b.last;
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      k = cyc;
   endtask
   task automatic get(input string name, input logic [15:0] res, input int lat, input int k);
      int n = 0;
      while (!bus.out_valid && n < 60) begin
         tick();
         n++;
      end
      chk({name, "_valid"}, 32'(bus.out_valid), 1);
      chk({name, "_result"}, 32'(bus.result), 32'(res));
      chk({name, "_latency"}, cyc - k, lat);
      if (bus.out_ready) begin
         tick();
         chk({name, "_valid_drop"}, 32'(bus.out_valid), 0);
         chk({name, "_in_ready_back"}, 32'(bus.in_ready), 1);
      end
   endtask
   initial begin
      int   k;
      logic seen;
      bus.in_valid = 1'b0;
      bus.in_last = 1'b0;
      bus.mantissa_A_in = '0;
      bus.mantissa_B_in = '0;
      bus.mantissa_C_in = '0;
      bus.mantissa_D_in = '0;
      {bus.sign_D, bus.sign_C, bus.sign_B, bus.sign_A} = 4'h0;
      bus.max_exponent = '0;
      bus.out_ready = 1'b1;
      tv.push_back(mk(ALL400, 4'h0, 5'd15, 1'b1, 16'h4400, 4));
      tv.push_back(mk(ALL400, 4'b1100, 5'd15, 1'b1, 16'h0000, 2));
      tv.push_back(mk(ALL400, 4'h0, 5'd15, 1'b0, 16'h0, 0));
      tv.push_back(mk(A400, 4'h0, 5'd17, 1'b1, 16'h4800, 3));
      for (int i = 0; i < 4; i++) tv.push_back(mk(ALL7FF, 4'h0, 5'd30, i == 3, 16'h7C00, 6));
      for (int i = 0; i < 4; i++) tv.push_back(mk(ALL7FF, 4'hF, 5'd30, i == 3, 16'hFC00, 6));
      for (int i = 0; i < 4; i++) tv.push_back(mk(ALL7FF, 4'h0, 5'd26, i == 3, 16'h7BFF, 6));
      for (int i = 0; i < 5; i++) tv.push_back(mk(ALL7FF, 4'h0, 5'd10, i == 4, 16'h3CFF, 6));
      tv.push_back(mk(A400, 4'h0, 5'd1, 1'b1, 16'h0400, 2));
      tv.push_back(mk(A200, 4'h0, 5'd1, 1'b1, 16'h0000, 3));
      tv.push_back(mk(A200, 4'h1, 5'd1, 1'b1, 16'h0000, 3));
      tv.push_back(mk(A400, 4'h0, 5'd20, 1'b0, 16'h0, 0));
      tv.push_back(mk(A400, 4'h0, 5'd18, 1'b1, 16'h5100, 2));
      tv.push_back(mk(A400, 4'h1, 5'd0, 1'b0, 16'h0, 0));
      tv.push_back(mk(A400, 4'h0, 5'd20, 1'b1, 16'h5000, 2));
      tv.push_back(mk(A4B7FF, 4'b0010, 5'd15, 1'b1, 16'hBBFE, 3));
      repeat (2) tick();
      reset = 1'b0;
      chk("reset_out_valid", 32'(bus.out_valid), 0);
      chk("reset_result", 32'(bus.result), 0);
      chk("reset_in_ready", 32'(bus.in_ready), 1);
      for (int i = 0; i < tv.size(); i++) begin
         send(tv[i], k);
         if (tv[i].last) get($sformatf("vec%0d", i), tv[i].res, tv[i].lat, k);
      end
      bus.out_ready = 1'b0;
      send(tv[0], k);
      get("bp", 16'h4400, 4, k);
      for (int c = 0; c < 5; c++) begin
         tick();
         chk("bp_hold_valid", 32'(bus.out_valid), 1);
         chk("bp_hold_result", 32'(bus.result), 32'h4400);
         chk("bp_hold_in_ready", 32'(bus.in_ready), 0);
      end
      bus.out_ready = 1'b1;
      tick();
      chk("bp_release_valid", 32'(bus.out_valid), 0);
      chk("bp_release_in_ready", 32'(bus.in_ready), 1);
      send(tv[4], k);
      send(tv[5], k);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("acc_rst_in_ready", 32'(bus.in_ready), 1);
      chk("acc_rst_out_valid", 32'(bus.out_valid), 0);
      send(tv[0], k);
      get("after_acc_rst", 16'h4400, 4, k);
      for (int i = 4; i < 8; i++) send(tv[i], k);
      tick();
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      seen = bus.out_valid;
      for (int c = 0; c < 12; c++) begin
         tick();
         seen = seen | bus.out_valid;
      end
      chk("norm_rst_no_valid", 32'(seen), 0);
      chk("norm_rst_in_ready", 32'(bus.in_ready), 1);
      send(tv[0], k);
      get("after_norm_rst", 16'h4400, 4, k);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
